// File: rtl/trap_pkg.sv
// Shared cause codes and FSM state encoding for the trap sequencer.
package trap_pkg;

    localparam logic [3:0] CAUSE_IMISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0] CAUSE_LMISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_SMISALIGN = 4'd6;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_ENTER,
        ST_HANDLER,
        ST_RETURN,
        ST_LOCKUP
    } trap_state_e;

endpackage

// File: rtl/misalign_check.sv
// Combinational alignment checks for branch targets, loads and stores.
module misalign_check
    import trap_pkg::*;
(
    input  logic        memtoreg,
    input  logic [3:0]  memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] daddr,
    input  logic        branch_taken,
    input  logic [31:0] target,
    output logic        instr_mis,
    output logic        load_mis,
    output logic        store_mis
);

    logic half_ld;
    logic word_ld;

    // LH/LHU need halfword alignment, LW needs word alignment; byte loads never fault.
    assign half_ld   = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign word_ld   = (funct3 == 3'b010);

    assign instr_mis = branch_taken && (target[1:0] != 2'b00);
    assign load_mis  = memtoreg && ((half_ld && daddr[0]) || (word_ld && (daddr[1:0] != 2'b00)));
    assign store_mis = ((memwrite == 4'b0011) && daddr[0]) ||
                       ((memwrite == 4'b1111) && (daddr[1:0] != 2'b00));

endmodule

// File: rtl/trap_unit.sv
// Exception sequencer: fault detection, trap registers, mret return and double-fault lockup.
//
// state   | meaning
// RUN     | normal execution, faults trap here
// ENTER   | redirect fetch to handler, squash wrong-path instruction
// HANDLER | executing handler, waits for mret; any fault locks up
// RETURN  | redirect fetch to mepc+4, squash wrong-path instruction
// LOCKUP  | double fault, everything killed until reset
module trap_unit
    import trap_pkg::*;
#(
    parameter logic [31:0] HANDLER_BASE = 32'h0000_0100,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instr_valid,
    input  logic [31:0]      pc,
    input  logic             opinvalid,
    input  logic             memtoreg,
    input  logic [3:0]       memwrite,
    input  logic [2:0]       funct3,
    input  logic [31:0]      daddr,
    input  logic             branch_taken,
    input  logic [31:0]      target,
    input  logic             mret,
    output logic             kill,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      mepc,
    output logic [31:0]      mtval,
    output logic [3:0]       mcause,
    output logic             in_handler,
    output logic             lockup,
    output logic [CNT_W-1:0] trap_count
);

    trap_state_e      state_q, state_d;
    logic [31:0]      mepc_q, mepc_d;
    logic [31:0]      mtval_q, mtval_d;
    logic [3:0]       mcause_q, mcause_d;
    logic [CNT_W-1:0] trap_count_q, trap_count_d;

    logic        instr_mis, load_mis, store_mis;
    logic        illegal;
    logic        fault;
    logic [3:0]  fault_cause;
    logic [31:0] fault_tval;

    misalign_check u_misalign (
        .memtoreg     (memtoreg),
        .memwrite     (memwrite),
        .funct3       (funct3),
        .daddr        (daddr),
        .branch_taken (branch_taken),
        .target       (target),
        .instr_mis    (instr_mis),
        .load_mis     (load_mis),
        .store_mis    (store_mis)
    );

    // mret is only illegal outside a handler; in HANDLER it is the return path.
    assign illegal = opinvalid || (mret && (state_q == ST_RUN));
    assign fault   = instr_valid && (illegal || instr_mis || load_mis || store_mis);

    always_comb begin
        fault_cause = CAUSE_SMISALIGN;
        fault_tval  = daddr;
        if (illegal) begin
            fault_cause = CAUSE_ILLEGAL;
            fault_tval  = 32'h0;
        end else if (instr_mis) begin
            fault_cause = CAUSE_IMISALIGN;
            fault_tval  = target;
        end else if (load_mis) begin
            fault_cause = CAUSE_LMISALIGN;
        end
    end

    always_comb begin
        state_d      = state_q;
        mepc_d       = mepc_q;
        mtval_d      = mtval_q;
        mcause_d     = mcause_q;
        trap_count_d = trap_count_q;
        kill         = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        in_handler   = 1'b0;
        lockup       = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (fault) begin
                    kill     = 1'b1;
                    mepc_d   = pc;
                    mcause_d = fault_cause;
                    mtval_d  = fault_tval;
                    if (trap_count_q != '1) begin
                        trap_count_d = trap_count_q + CNT_W'(1);
                    end
                    state_d  = ST_ENTER;
                end
            end
            ST_ENTER: begin
                kill        = 1'b1;
                redirect    = 1'b1;
                redirect_pc = HANDLER_BASE;
                in_handler  = 1'b1;
                state_d     = ST_HANDLER;
            end
            ST_HANDLER: begin
                in_handler = 1'b1;
                if (instr_valid && mret) begin
                    kill    = 1'b1;
                    state_d = ST_RETURN;
                end else if (fault) begin
                    kill    = 1'b1;
                    state_d = ST_LOCKUP;
                end
            end
            ST_RETURN: begin
                kill        = 1'b1;
                redirect    = 1'b1;
                redirect_pc = mepc_q + 32'd4;
                in_handler  = 1'b1;
                state_d     = ST_RUN;
            end
            ST_LOCKUP: begin
                kill   = 1'b1;
                lockup = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            mepc_q       <= 32'h0;
            mtval_q      <= 32'h0;
            mcause_q     <= 4'h0;
            trap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            mepc_q       <= mepc_d;
            mtval_q      <= mtval_d;
            mcause_q     <= mcause_d;
            trap_count_q <= trap_count_d;
        end
    end

    assign mepc       = mepc_q;
    assign mtval      = mtval_q;
    assign mcause     = mcause_q;
    assign trap_count = trap_count_q;

endmodule

// File: tb/tb_trap_unit.sv
// Scoreboard bench for trap_unit: directed per-cycle vectors push expectations, a monitor checks them.
module tb_trap_unit;

    // Narrow counter so saturation is reachable in a short run.
    localparam int TB_CNT_W = 6;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                instr_valid, opinvalid, memtoreg, branch_taken, mret;
    logic [31:0]         pc, daddr, target;
    logic [3:0]          memwrite;
    logic [2:0]          funct3;
    logic                kill, redirect, in_handler, lockup;
    logic [31:0]         redirect_pc, mepc, mtval;
    logic [3:0]          mcause;
    logic [TB_CNT_W-1:0] trap_count;

    always #5 clk = ~clk;

    trap_unit #(.HANDLER_BASE(32'h0000_0100), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .pc(pc),
        .opinvalid(opinvalid), .memtoreg(memtoreg), .memwrite(memwrite),
        .funct3(funct3), .daddr(daddr), .branch_taken(branch_taken),
        .target(target), .mret(mret), .kill(kill), .redirect(redirect),
        .redirect_pc(redirect_pc), .mepc(mepc), .mtval(mtval), .mcause(mcause),
        .in_handler(in_handler), .lockup(lockup), .trap_count(trap_count)
    );

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        opinv;
        logic        ld;
        logic [3:0]  mw;
        logic [2:0]  f3;
        logic [31:0] daddr;
        logic        br;
        logic [31:0] tgt;
        logic        mret;
    } stim_t;

    typedef struct {
        logic        kill;
        logic        redirect;
        logic [31:0] rpc;
        logic        inh;
        logic        lock;
        logic [31:0] mepc;
        logic [3:0]  mcause;
        logic [31:0] mtval;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{iv: 1'b0, pc: 32'h0, opinv: 1'b0, ld: 1'b0, mw: 4'h0, f3: 3'h0,
              daddr: 32'h0, br: 1'b0, tgt: 32'h0, mret: 1'b0};
        return s;
    endfunction

    function automatic stim_t nop(input logic [31:0] p);
        stim_t s = idle();
        s.iv = 1'b1;
        s.pc = p;
        return s;
    endfunction

    function automatic stim_t op_illegal(input logic [31:0] p);
        stim_t s = nop(p);
        s.opinv = 1'b1;
        return s;
    endfunction

    function automatic stim_t op_mret(input logic [31:0] p);
        stim_t s = nop(p);
        s.mret = 1'b1;
        return s;
    endfunction

    function automatic stim_t op_load(input logic [31:0] p, input logic [2:0] f, input logic [31:0] a);
        stim_t s = nop(p);
        s.ld    = 1'b1;
        s.f3    = f;
        s.daddr = a;
        return s;
    endfunction

    function automatic stim_t op_store(input logic [31:0] p, input logic [3:0] m, input logic [31:0] a);
        stim_t s = nop(p);
        s.mw    = m;
        s.f3    = 3'b010;
        s.daddr = a;
        return s;
    endfunction

    function automatic stim_t op_branch(input logic [31:0] p, input logic [31:0] t);
        stim_t s = nop(p);
        s.br  = 1'b1;
        s.tgt = t;
        return s;
    endfunction

    function automatic exp_t ex(input logic k, input logic r, input logic [31:0] rp,
                                input logic ih, input logic lk, input logic [31:0] ep,
                                input logic [3:0] mc, input logic [31:0] tv, input int c);
        exp_t e;
        e = '{kill: k, redirect: r, rpc: rp, inh: ih, lock: lk, mepc: ep,
              mcause: mc, mtval: tv, cnt: 16'(c)};
        return e;
    endfunction

    task automatic apply(input stim_t s);
        instr_valid  = s.iv;
        pc           = s.pc;
        opinvalid    = s.opinv;
        memtoreg     = s.ld;
        memwrite     = s.mw;
        funct3       = s.f3;
        daddr        = s.daddr;
        branch_taken = s.br;
        target       = s.tgt;
        mret         = s.mret;
    endtask

    task automatic step(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        apply(s);
        exp_q.push_back(e);
    endtask

    // Asynchronous assert just after an edge, release away from the next edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        apply(idle());
        exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("kill",        32'(kill),        32'(e.kill));
                chk("redirect",    32'(redirect),    32'(e.redirect));
                chk("redirect_pc", redirect_pc,      e.rpc);
                chk("in_handler",  32'(in_handler),  32'(e.inh));
                chk("lockup",      32'(lockup),      32'(e.lock));
                chk("mepc",        mepc,             e.mepc);
                chk("mcause",      32'(mcause),      32'(e.mcause));
                chk("mtval",       mtval,            e.mtval);
                chk("trap_count",  32'(trap_count),  32'(e.cnt));
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        apply(idle());
        do_reset();

        // Illegal opcode trap, handler, mret back to 0x44.
        step(nop(32'h3c),         ex(0, 0, 0,        0, 0, 32'h0,  0, 0, 0));
        step(op_illegal(32'h40),  ex(1, 0, 0,        0, 0, 32'h0,  0, 0, 0));
        step(idle(),              ex(1, 1, 32'h100,  1, 0, 32'h40, 2, 0, 1));
        step(nop(32'h100),        ex(0, 0, 0,        1, 0, 32'h40, 2, 0, 1));
        step(idle(),              ex(0, 0, 0,        1, 0, 32'h40, 2, 0, 1));
        step(op_mret(32'h104),    ex(1, 0, 0,        1, 0, 32'h40, 2, 0, 1));
        step(idle(),              ex(1, 1, 32'h44,   1, 0, 32'h40, 2, 0, 1));
        step(nop(32'h44),         ex(0, 0, 0,        0, 0, 32'h40, 2, 0, 1));

        // Misaligned word load; unsigned byte load to the same address is fine.
        step(op_load(32'h80, 3'b010, 32'h1002), ex(1, 0, 0,       0, 0, 32'h40, 2, 0,         1));
        step(idle(),                            ex(1, 1, 32'h100, 1, 0, 32'h80, 4, 32'h1002, 2));
        step(op_load(32'h100, 3'b100, 32'h1002),ex(0, 0, 0,       1, 0, 32'h80, 4, 32'h1002, 2));
        step(op_mret(32'h104),                  ex(1, 0, 0,       1, 0, 32'h80, 4, 32'h1002, 2));
        step(idle(),                            ex(1, 1, 32'h84,  1, 0, 32'h80, 4, 32'h1002, 2));
        step(nop(32'h84),                       ex(0, 0, 0,       0, 0, 32'h80, 4, 32'h1002, 2));
        step(op_load(32'h88, 3'b100, 32'h1002), ex(0, 0, 0,       0, 0, 32'h80, 4, 32'h1002, 2));
        step(op_load(32'h8c, 3'b001, 32'h1006), ex(0, 0, 0,       0, 0, 32'h80, 4, 32'h1002, 2));

        // Misaligned halfword store.
        step(op_store(32'h90, 4'b0011, 32'h2005), ex(1, 0, 0,       0, 0, 32'h80, 4, 32'h1002, 2));
        step(idle(),                              ex(1, 1, 32'h100, 1, 0, 32'h90, 6, 32'h2005, 3));
        step(op_mret(32'h100),                    ex(1, 0, 0,       1, 0, 32'h90, 6, 32'h2005, 3));
        step(idle(),                              ex(1, 1, 32'h94,  1, 0, 32'h90, 6, 32'h2005, 3));

        // Target misalignment outranks a simultaneous load misalignment.
        s = op_branch(32'h94, 32'h202);
        s.ld = 1'b1; s.f3 = 3'b001; s.daddr = 32'h11;
        step(s,                ex(1, 0, 0,       0, 0, 32'h90, 6, 32'h2005, 3));
        step(idle(),           ex(1, 1, 32'h100, 1, 0, 32'h94, 0, 32'h202,  4));
        step(op_mret(32'h100), ex(1, 0, 0,       1, 0, 32'h94, 0, 32'h202,  4));
        step(idle(),           ex(1, 1, 32'h98,  1, 0, 32'h94, 0, 32'h202,  4));

        // mret outside a handler is illegal; then a store fault inside the handler locks up.
        step(op_mret(32'h98),                     ex(1, 0, 0,       0, 0, 32'h94, 0, 32'h202, 4));
        step(idle(),                              ex(1, 1, 32'h100, 1, 0, 32'h98, 2, 0,       5));
        step(op_store(32'h100, 4'b1111, 32'h3),   ex(1, 0, 0,       1, 0, 32'h98, 2, 0,       5));
        step(idle(),                              ex(1, 0, 0,       0, 1, 32'h98, 2, 0,       5));
        step(op_illegal(32'h104),                 ex(1, 0, 0,       0, 1, 32'h98, 2, 0,       5));
        step(op_mret(32'h108),                    ex(1, 0, 0,       0, 1, 32'h98, 2, 0,       5));
        do_reset();

        // Illegal outranks target misalignment.
        s = op_branch(32'h200, 32'h202);
        s.opinv = 1'b1;
        step(s,                ex(1, 0, 0,       0, 0, 32'h0,   0, 0, 0));
        step(idle(),           ex(1, 1, 32'h100, 1, 0, 32'h200, 2, 0, 1));
        step(nop(32'h100),     ex(0, 0, 0,       1, 0, 32'h200, 2, 0, 1));
        step(op_mret(32'h104), ex(1, 0, 0,       1, 0, 32'h200, 2, 0, 1));
        step(idle(),           ex(1, 1, 32'h204, 1, 0, 32'h200, 2, 0, 1));

        // Reset during ENTER drops the redirect at once.
        step(op_load(32'h300, 3'b010, 32'h1001), ex(1, 0, 0, 0, 0, 32'h200, 2, 0, 1));
        do_reset();

        // mepc+4 wraps to zero.
        step(op_illegal(32'hFFFF_FFFC), ex(1, 0, 0,       0, 0, 32'h0,         0, 0, 0));
        step(idle(),                    ex(1, 1, 32'h100, 1, 0, 32'hFFFF_FFFC, 2, 0, 1));
        step(op_mret(32'h100),          ex(1, 0, 0,       1, 0, 32'hFFFF_FFFC, 2, 0, 1));
        step(idle(),                    ex(1, 1, 32'h0,   1, 0, 32'hFFFF_FFFC, 2, 0, 1));
        step(nop(32'h0),                ex(0, 0, 0,       0, 0, 32'hFFFF_FFFC, 2, 0, 1));

        // Counter saturation: drive more traps than the counter can hold.
        do_reset();
        for (int n = 1; n <= CNT_MAX + 8; n++) begin
            int cur;
            int nxt;
            cur = (n - 1 > CNT_MAX) ? CNT_MAX : n - 1;
            nxt = (n > CNT_MAX) ? CNT_MAX : n;
            step(op_illegal(32'h40), ex(1, 0, 0, 0, 0, (n == 1) ? 32'h0 : 32'h40,
                                        (n == 1) ? 4'd0 : 4'd2, 0, cur));
            step(idle(),             ex(1, 1, 32'h100, 1, 0, 32'h40, 2, 0, nxt));
            step(op_mret(32'h100),   ex(1, 0, 0,       1, 0, 32'h40, 2, 0, nxt));
            step(idle(),             ex(1, 1, 32'h44,  1, 0, 32'h40, 2, 0, nxt));
        end
        step(nop(32'h44), ex(0, 0, 0, 0, 0, 32'h40, 2, 0, CNT_MAX));

        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
